// File: rtl/smac_pkg.sv
// rtl/smac_pkg.sv - shared state type, default sizes and precision helper for bitplane_mac_ctrl
package smac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ctrl_state_t;

  localparam int SMAC_M_DEF = 16;
  localparam int SMAC_N_DEF = 8;

  // Out-of-range precision (0 or above the plane count) falls back to full precision.
  function automatic int eff_prec(input int prec, input int n);
    return (prec <= 0 || prec > n) ? n : prec;
  endfunction

endpackage

// File: rtl/bitplane_mac_ctrl_if.sv
// rtl/bitplane_mac_ctrl_if.sv - scheduler handshake and adder-tree plane bus of bitplane_mac_ctrl
import smac_pkg::*;

interface bitplane_mac_ctrl_if #(
  parameter int M = SMAC_M_DEF,
  parameter int N = SMAC_N_DEF
);
  localparam int PC_W  = $clog2(M) + 2;
  localparam int ACC_W = N + $clog2(M) + 1;
  localparam int IW    = $clog2(N);
  localparam int PW    = IW + 1;

  logic             start;
  logic [PW-1:0]    prec;
  logic             signed_mode;
  logic             busy;
  logic             plane_en;
  logic [IW-1:0]    plane_idx;
  logic             plane_msb;
  logic [PC_W-1:0]  pc_in;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport master (
    output start, prec, signed_mode, pc_in, res_ready,
    input  busy, plane_en, plane_idx, plane_msb, res_valid, res_data
  );

  modport slave (
    input  start, prec, signed_mode, pc_in, res_ready,
    output busy, plane_en, plane_idx, plane_msb, res_valid, res_data
  );

endinterface

// File: rtl/bitplane_mac_ctrl_shift_acc.sv
// rtl/bitplane_mac_ctrl_shift_acc.sv - sign-extend, shift by plane index and accumulate signed popcounts
module shift_acc #(
  parameter int PC_W  = 6,
  parameter int ACC_W = 13,
  parameter int IW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PC_W-1:0]  pc,
  input  logic [IW-1:0]    shamt,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] term;

  // Left shift of the sign-extended value is the same as arithmetic scaling by 2^shamt.
  assign term = {{(ACC_W-PC_W){pc[PC_W-1]}}, pc} << shamt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/bitplane_mac_ctrl.sv
// rtl/bitplane_mac_ctrl.sv - bit-serial MAC sequencer; SMAC_CTRL_RELU_EN clamps negative results to 0
import smac_pkg::*;

module bitplane_mac_ctrl #(
  parameter int M = SMAC_M_DEF,
  parameter int N = SMAC_N_DEF
) (
  input logic                 clk,
  input logic                 rst,
  bitplane_mac_ctrl_if.slave  bus
);

  localparam int PC_W  = $clog2(M) + 2;
  localparam int ACC_W = N + $clog2(M) + 1;
  localparam int IW    = $clog2(N);
  localparam int PW    = IW + 1;

  ctrl_state_t      state_q, state_d;
  logic [PW-1:0]    p_q;
  logic             signed_q;
  logic [IW-1:0]    idx_q;
  logic             accept;
  logic             last;
  logic             in_run;
  logic [ACC_W-1:0] acc;

  assign in_run = (state_q == RUN);
  assign last   = ({1'b0, idx_q} == (p_q - PW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        p_q      <= PW'(eff_prec(int'(bus.prec), N));
        signed_q <= bus.signed_mode;
        idx_q    <= '0;
      end else if (in_run) begin
        // Wrap back to 0 on the last plane so the index idles at 0.
        idx_q <= last ? '0 : idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.busy      = 1'b0;
    bus.plane_en  = 1'b0;
    bus.res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy     = 1'b1;
        bus.plane_en = 1'b1;
        if (last) state_d = HOLD;
      end
      HOLD: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          accept  = bus.start;
          state_d = bus.start ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.plane_idx = idx_q;
  assign bus.plane_msb = in_run & signed_q & last;

  shift_acc #(
    .PC_W  (PC_W),
    .ACC_W (ACC_W),
    .IW    (IW)
  ) u_shift_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (in_run),
    .pc    (bus.pc_in),
    .shamt (idx_q),
    .acc   (acc)
  );

`ifdef SMAC_CTRL_RELU_EN
  assign bus.res_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign bus.res_data = acc;
`endif

endmodule

// File: tb/tb_bitplane_mac_ctrl.sv
// tb/tb_bitplane_mac_ctrl.sv - directed self-checking bench for bitplane_mac_ctrl (M=16, N=8)
module tb_bitplane_mac_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic signed [5:0] pc_tab [8];

`ifdef SMAC_CTRL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  always #5 clk = ~clk;

  bitplane_mac_ctrl_if #(.M(16), .N(8)) bus ();

  // The adder tree answers combinationally for whichever plane is selected.
  assign bus.pc_in = pc_tab[bus.plane_idx];

  bitplane_mac_ctrl #(.M(16), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [12:0] exp_res(input int v);
    return 13'((RELU && v < 0) ? 0 : v);
  endfunction

  task automatic set_pc(input int v);
    for (int i = 0; i < 8; i++) pc_tab[i] = 6'(v);
  endtask

  task automatic launch(input int p, input bit sm);
    @(negedge clk);
    bus.prec        = 4'(p);
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic transfer();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    tests_run++;
    if (bus.plane_en !== 1'b0) begin tests_failed++; $display("FAIL reset_plane_en: got %b required 0", bus.plane_en); end
    tests_run++;
    if (bus.plane_msb !== 1'b0) begin tests_failed++; $display("FAIL reset_plane_msb: got %b required 0", bus.plane_msb); end
    tests_run++;
    if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b required 0", bus.res_valid); end
    tests_run++;
    if (bus.plane_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_plane_idx: got %0d required 0", bus.plane_idx); end
    tests_run++;
    if (bus.res_data !== 13'd0) begin tests_failed++; $display("FAIL reset_res_data: got %0d required 0", bus.res_data); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_full();
    int bad = 0;
    set_pc(3);
    launch(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (bus.plane_en !== 1'b1 || bus.plane_idx !== 3'(k) || bus.plane_msb !== 1'b0 ||
          bus.res_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL t1_planes: %0d bad plane cycles, required 0", bad); end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.plane_en !== 1'b0) begin
      tests_failed++; $display("FAIL t1_valid_cycle9: res_valid=%b plane_en=%b required 1/0", bus.res_valid, bus.plane_en);
    end
    tests_run++;
    if (bus.res_data !== 13'd765) begin tests_failed++; $display("FAIL t1_res_data: got %0d required 765", bus.res_data); end
    transfer();
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL t1_idle_after_xfer: res_valid=%b busy=%b required 0/0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_signed_msb();
    int bad = 0;
    logic [12:0] e;
    set_pc(0);
    pc_tab[7] = -6'sd16;
    launch(8, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (bus.plane_en !== 1'b1 || bus.plane_idx !== 3'(k) || bus.plane_msb !== (k == 7)) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL t2_msb_only_idx7: %0d bad plane cycles, required 0", bad); end
    e = exp_res(-2048);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== e) begin
      tests_failed++;
      $display("FAIL t2_res_data: valid=%b got %0d required %0d", bus.res_valid, $signed(bus.res_data), $signed(e));
    end
    transfer();
  endtask

  task automatic test_reduced_prec();
    int prec_v [4] = '{4, 0, 12, 1};
    bit sm_v   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int pc_v   [4] = '{1, 3, 1, -5};
    int cnt_v  [4] = '{4, 8, 8, 1};
    int res_v  [4] = '{15, 765, 255, -5};
    for (int t = 0; t < 4; t++) begin
      int cnt = 0;
      int bad = 0;
      int msb_cnt = 0;
      logic [12:0] e;
      set_pc(pc_v[t]);
      launch(prec_v[t], sm_v[t]);
      for (int c = 0; c < 12 && bus.res_valid !== 1'b1; c++) begin
        if (bus.plane_en === 1'b1) begin
          if (bus.plane_idx !== 3'(cnt)) bad++;
          if (bus.plane_msb === 1'b1) begin
            msb_cnt++;
            if (bus.plane_idx !== 3'(cnt_v[t] - 1)) bad++;
          end
          cnt++;
        end else bad++;
        @(negedge clk);
      end
      tests_run++;
      if (cnt != cnt_v[t] || bad != 0) begin
        tests_failed++; $display("FAIL t3_planes[%0d]: %0d planes (%0d bad) required %0d", t, cnt, bad, cnt_v[t]);
      end
      tests_run++;
      if (msb_cnt != (sm_v[t] ? 1 : 0)) begin
        tests_failed++; $display("FAIL t3_msb[%0d]: %0d msb cycles required %0d", t, msb_cnt, sm_v[t] ? 1 : 0);
      end
      e = exp_res(res_v[t]);
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== e) begin
        tests_failed++;
        $display("FAIL t3_res[%0d]: valid=%b got %0d required %0d", t, bus.res_valid, $signed(bus.res_data), $signed(e));
      end
      transfer();
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int bad_hold = 0;
    set_pc(1);
    launch(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (bus.plane_en !== 1'b1 || bus.plane_idx !== 3'(k)) bad++;
      bus.start = (k == 0);
      bus.prec  = (k == 0) ? 4'd8 : 4'd3;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL t4_run_start_ignored: %0d bad plane cycles, required 0", bad); end
    bus.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd7 || bus.plane_en !== 1'b0) bad_hold++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    tests_run++;
    if (bad_hold != 0) begin tests_failed++; $display("FAIL t4_hold_stable: %0d unstable cycles, required 0", bad_hold); end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd7) begin
      tests_failed++; $display("FAIL t4_still_held: valid=%b data=%0d required 1/7", bus.res_valid, bus.res_data);
    end
    transfer();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.plane_en !== 1'b0) begin
      tests_failed++; $display("FAIL t4_idle: busy=%b plane_en=%b required 0/0", bus.busy, bus.plane_en);
    end
  endtask

  task automatic test_back_to_back();
    set_pc(1);
    launch(2, 1'b0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd3) begin
      tests_failed++; $display("FAIL t5_first_res: valid=%b data=%0d required 1/3", bus.res_valid, bus.res_data);
    end
    set_pc(2);
    bus.prec        = 4'd2;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    tests_run++;
    if (bus.plane_en !== 1'b1 || bus.plane_idx !== 3'd0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_rerun: plane_en=%b idx=%0d res_valid=%b required 1/0/0", bus.plane_en, bus.plane_idx, bus.res_valid);
    end
    tests_run++;
    if (bus.res_data !== 13'd0) begin tests_failed++; $display("FAIL t5_acc_cleared: got %0d required 0", bus.res_data); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd6) begin
      tests_failed++; $display("FAIL t5_second_res: valid=%b data=%0d required 1/6", bus.res_valid, bus.res_data);
    end
    transfer();
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    set_pc(1);
    launch(8, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.plane_idx !== 3'd3) begin tests_failed++; $display("FAIL t6_at_idx3: got %0d required 3", bus.plane_idx); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.plane_en, bus.plane_msb, bus.res_valid} !== 4'b0 || bus.plane_idx !== 3'd0 || bus.res_data !== 13'd0) begin
      tests_failed++;
      $display("FAIL t6_outputs_cleared: busy/en/msb/valid=%b idx=%0d data=%0d required 0000/0/0",
               {bus.busy, bus.plane_en, bus.plane_msb, bus.res_valid}, bus.plane_idx, bus.res_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL t6_no_result: %0d cycles with result/busy, required 0", bad); end
    set_pc(2);
    launch(3, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd14) begin
      tests_failed++; $display("FAIL t6_after_reset_res: valid=%b data=%0d required 1/14", bus.res_valid, bus.res_data);
    end
    transfer();
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.prec        = '0;
    bus.signed_mode = 1'b0;
    bus.res_ready   = 1'b0;
    set_pc(0);
    test_reset();
    test_unsigned_full();
    test_signed_msb();
    test_reduced_prec();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
